// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx -- serial UART transmitter, 8N1 frames, LSB first.
//
// A one-entry holding register sits in front of the shift register, so the
// producer can hand over the next byte while the current frame is still
// shifting out. When a byte is waiting at the last cycle of a stop bit, the
// next start bit follows with no idle gap.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (8E1, 11-bit frames). If the macro
// is left undefined, the design builds as plain 8N1 with no parity logic.
//
// Parameters:
//   CLKS_PER_BIT  sys_clk cycles per serial bit (>= 2)
//
// Ports:
//   sys_clk   in   system clock, all logic on its rising edge
//   rst       in   synchronous reset, active low
//   tx_data   in   [7:0] byte to send, sampled on handshake
//   tx_valid  in   producer has a byte
//   tx_ready  out  holding register empty; accepted when tx_valid && tx_ready
//   TX        out  serial line, registered, idles high
//   busy      out  frame in flight or holding register full
// ----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       TX,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic [7:0]       hold_reg;
    logic             hold_valid;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    logic bit_done;
    logic accept;
    logic load;

    assign tx_ready = !hold_valid;
    assign busy     = (state != IDLE) || hold_valid;
    assign bit_done = (baud_cnt == BAUD_LAST);
    assign accept   = tx_valid && !hold_valid;

    // The holding register drains into the shifter either from idle or at the
    // final cycle of a stop bit (back-to-back frames). Because a load only
    // happens while hold_valid is set, tx_ready is low in that cycle and a new
    // acceptance can never coincide with it.
    always_comb begin
        load = 1'b0;
        if (hold_valid) begin
            if (state == IDLE)
                load = 1'b1;
            else if (state == STOP && bit_done)
                load = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            hold_reg   <= '0;
            hold_valid <= 1'b0;
            TX         <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            // Holding register
            if (accept) begin
                hold_reg   <= tx_data;
                hold_valid <= 1'b1;
            end else if (load) begin
                hold_valid <= 1'b0;
            end

            // Baud counter runs in every non-idle state and wraps per bit
            if (state != IDLE) begin
                if (bit_done)
                    baud_cnt <= '0;
                else
                    baud_cnt <= baud_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    TX <= 1'b1;
                end

                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        TX      <= shift_reg[0];
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            TX    <= parity_bit;
`else
                            state <= STOP;
                            TX    <= 1'b1;
`endif
                        end else begin
                            // TX is registered, so drive the bit that will be
                            // at position 0 after this shift.
                            shift_reg <= shift_reg >> 1;
                            TX        <= shift_reg[1];
                            bit_cnt   <= bit_cnt + 3'd1;
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        state <= STOP;
                        TX    <= 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (bit_done) begin
                        state <= IDLE;
                        TX    <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    TX    <= 1'b1;
                end
            endcase

            // A load overrides the idle/stop handling above: it is the only
            // path into START, whether from idle or straight out of a stop bit.
            if (load) begin
                shift_reg <= hold_reg;
                state     <= START;
                baud_cnt  <= '0;
                TX        <= 1'b0;
`ifdef UART_TX_PARITY_EN
                parity_bit <= ^hold_reg;
`endif
            end
        end
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter: 8N1 frames (8E1 with parity option), LSB first.
- Upstream stage of the receive path. Its TX output drives the serial line that the receiver's RX input samples; the loopback bench connects them directly.
- Runs on sys_clk from the clock wizard.
- One-entry holding register, so the next byte can be accepted while the current frame is shifting.

Parameters:
- CLKS_PER_BIT, 868: sys_clk cycles per serial bit. Legal range >= 2. Baud counter width is $clog2(CLKS_PER_BIT).

Ports:
- sys_clk, input, 1: system clock; all logic on its rising edge.
- rst, input, 1: reset, synchronous, active-low.
- tx_data, input, 8: byte to send; sampled on handshake.
- tx_valid, input, 1: producer has a byte.
- tx_ready, output, 1: holding register empty; byte accepted on a cycle where tx_valid && tx_ready.
- TX, output, 1: serial line, registered; idles high.
- busy, output, 1: high while a frame is in flight or the holding register is full.

Behaviour:
- Reset (rst=0 at an edge):
  - After that edge: TX=1, tx_ready=1, busy=0, hold_valid=0, state=IDLE, counters=0.
  - Applies mid-frame too: the frame is truncated, the line returns high, and the held byte is discarded.
- Handshake:
  - tx_ready = !hold_valid, combinational from a register.
  - Acceptance at edge N: hold_reg<=tx_data, hold_valid<=1.
  - tx_valid while tx_ready=0 is ignored; the producer must hold tx_data and tx_valid.
- State machine: IDLE -> START -> DATA -> (PARITY) -> STOP.
  - IDLE: TX=1. If hold_valid, at the next edge: shift_reg<=hold_reg, hold_valid<=0, state<=START, TX<=0, baud_cnt<=0.
  - START, DATA, PARITY, STOP: each bit is held exactly CLKS_PER_BIT cycles. baud_cnt counts 0..CLKS_PER_BIT-1, and the bit advances when baud_cnt==CLKS_PER_BIT-1.
  - DATA: TX = shift_reg[0]; shift right each bit. bit_cnt counts 0..7; after bit 7, go to PARITY (option on) or STOP.
  - STOP: TX=1 for CLKS_PER_BIT cycles.
    - At its last cycle, if hold_valid: load the shifter and go straight to START. TX goes 0 on the very next cycle, with no idle gap.
    - Otherwise go to IDLE.
- Latency: byte accepted at edge N -> TX falls after edge N+1. Frame length is 10*CLKS_PER_BIT cycles (11* with parity).
- Simultaneous events:
  - The hold register is emptied into the shifter in the same cycle tx_ready is low, so a new acceptance cannot collide with the load.
  - tx_ready rises the cycle after the load.
- busy = (state!=IDLE) || hold_valid.
- The shift register and tx_data are not modified by a tx_valid that was not accepted.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - TX = even parity (XOR of the 8 data bits), computed at load time and held for CLKS_PER_BIT cycles.
  - Frame is 11 bits.
- Undefined: no PARITY state and no parity logic; the frame is 10 bits (8N1).

Test Plan (CLKS_PER_BIT=4):
- Reset then idle: rst=0 for 2 cycles, then 1 -> TX=1, tx_ready=1, busy=0 held for 50 cycles.
- Single byte: tx_data=0xA5 with a one-cycle tx_valid.
  - TX waveform: 0, then 1,0,1,0,0,1,0,1, then 1; each bit held 4 cycles; start bit begins 2 edges after acceptance.
  - busy drops after 40 cycles of frame.
  - With UART_TX_PARITY_EN: parity bit 0 is inserted before stop, frame 44 cycles.
- Back-to-back: 0x00 then 0xFF, second offered as soon as tx_ready rises.
  - tx_ready rises 1 cycle after the start of the first frame.
  - The second start bit immediately follows the first stop bit (exactly 80 cycles total), no idle cycle.
  - With UART_TX_PARITY_EN: parity bits 0 and 0.
- Backpressure: hold full and tx_valid held with 0x3C -> tx_ready=0 and the byte is not captured until the hold frees; 0x3C is then transmitted intact.
- Reset mid-frame: rst=0 during DATA bit 3 -> TX=1 next edge, busy=0, tx_ready=1, and no residual bits after release.
- Loopback: TX wired to the receiver's RX, bytes 0x55, 0x81, 0xFF -> receiver data_out matches each byte and error stays 0.
